eth_mac_rx_frame: RTL

Receive-side frame engine of tri_mode_ethernet_mac, the counterpart of the transmit framer. It consumes the byte-wide GMII-style stream produced by the RGMII input stage and recovers frames. Functions: preamble/SFD detection, destination-address filtering, CRC32 check, FCS stripping and timeout. It drives the user receive AXIS interface, which has no backpressure.

---
 rtl/eth_mac_rx_frame.sv | 116 +++++++++++
 1 files changed

// File: rtl/eth_mac_rx_frame.sv
// eth_mac_rx_frame: GMII receive framer with preamble/SFD detection, DA filter, CRC32 check, FCS strip and timeout
module eth_mac_rx_frame #(
  parameter bit          C_FILTER_EN = 1'b1,
  parameter logic [47:0] C_LOCAL_MAC = 48'h0102_0304_0506,
  parameter int          C_TIMEOUT   = 3000
) (
  input  logic       rx_mac_aclk,
  input  logic       rx_mac_aresetn,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  input  logic [7:0] gmii_rxd,
  output logic [7:0] rx_axis_mac_tdata,
  output logic       rx_axis_mac_tvalid,
  output logic       rx_axis_mac_tlast,
  output logic       rx_axis_mac_tuser,
  output logic       rx_frame_good,
  output logic       rx_frame_bad,
  output logic       rx_frame_filtered
);
  localparam int CW = $clog2(C_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, FLUSH, DROP} state_t;
  state_t          state;
  logic [5:0][7:0] dly;
  logic [31:0]     crc, crc_nxt;
  logic [CW-1:0]   cnt;
  logic            err, bad_q, flush_1, wait_idle;
  logic [47:0]     da;
  logic            da_ok;
  always_comb begin
    crc_nxt = crc ^ {24'h0, gmii_rxd};
    for (int i = 0; i < 8; i++) crc_nxt = crc_nxt[0] ? (crc_nxt >> 1) ^ 32'hEDB8_8320 : crc_nxt >> 1;
  end
  // dly[4] holds DA byte 0 when byte 5 is on the wire
  assign da    = {dly[4:0], gmii_rxd};
  assign da_ok = !C_FILTER_EN || da == C_LOCAL_MAC || &da;
  always_ff @(posedge rx_mac_aclk or negedge rx_mac_aresetn) begin
    if (!rx_mac_aresetn) begin
      state              <= IDLE;
      dly                <= '0;
      crc                <= '0;
      cnt                <= '0;
      err                <= 1'b0;
      bad_q              <= 1'b0;
      flush_1            <= 1'b0;
      wait_idle          <= 1'b1;
      rx_axis_mac_tdata  <= '0;
      rx_axis_mac_tvalid <= 1'b0;
      rx_axis_mac_tlast  <= 1'b0;
      rx_axis_mac_tuser  <= 1'b0;
      rx_frame_good      <= 1'b0;
      rx_frame_bad       <= 1'b0;
      rx_frame_filtered  <= 1'b0;
    end else begin
      rx_axis_mac_tvalid <= 1'b0;
      rx_axis_mac_tlast  <= 1'b0;
      rx_axis_mac_tuser  <= 1'b0;
      rx_frame_good      <= 1'b0;
      rx_frame_bad       <= 1'b0;
      rx_frame_filtered  <= 1'b0;
      if (!gmii_rx_dv) wait_idle <= 1'b0;
      case (state)
        IDLE: if (gmii_rx_dv) state <= (gmii_rxd == 8'h55 && !wait_idle) ? PREAMBLE : DROP;
        PREAMBLE: begin
          if (!gmii_rx_dv) state <= IDLE;
          else if (gmii_rxd == 8'hD5) begin
            state <= DATA;
            crc   <= '1;
            cnt   <= '0;
            err   <= 1'b0;
          end else if (gmii_rxd != 8'h55) state <= DROP;
        end
        DATA: begin
          if (gmii_rx_dv) begin
            dly                <= {dly[4:0], gmii_rxd};
            crc                <= crc_nxt;
            cnt                <= cnt + 1'b1;
            err                <= err | gmii_rx_er;
            rx_axis_mac_tdata  <= dly[5];
            rx_axis_mac_tvalid <= cnt >= CW'(6);
            if (cnt == CW'(5) && !da_ok) begin
              rx_frame_filtered <= 1'b1;
              state             <= DROP;
            end else if (cnt == CW'(C_TIMEOUT - 1)) begin
              rx_axis_mac_tlast <= 1'b1;
              rx_axis_mac_tuser <= 1'b1;
              rx_frame_bad      <= 1'b1;
              state             <= DROP;
            end
          end else if (cnt >= CW'(7)) begin
            dly                <= {dly[4:0], 8'h00};
            rx_axis_mac_tdata  <= dly[5];
            rx_axis_mac_tvalid <= 1'b1;
            bad_q              <= crc != 32'hDEBB_20E3 || err || cnt < CW'(64);
            flush_1            <= 1'b1;
            state              <= FLUSH;
          end else begin
            rx_frame_bad <= 1'b1;
            state        <= IDLE;
          end
        end
        FLUSH: begin
          flush_1 <= 1'b0;
          if (flush_1) begin
            rx_axis_mac_tdata  <= dly[5];
            rx_axis_mac_tvalid <= 1'b1;
            rx_axis_mac_tlast  <= 1'b1;
            rx_axis_mac_tuser  <= bad_q;
            rx_frame_good      <= !bad_q;
            rx_frame_bad       <= bad_q;
          end else state <= IDLE;
        end
        default: if (!gmii_rx_dv) state <= IDLE;
      endcase
    end
  end
endmodule
